// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// ----------------
// Receiving end of a multiplexed 4-digit 7-segment display bus. The block
// watches the scanned {digit, seg} bus and waits until a digit slot has been
// stable for STABLE_CYCLES samples. It then decodes the segment pattern back
// into a hex nibble plus decimal point and assembles a 16-bit display word.
//
// Optional feature macro: SCAN_TIMEOUT_EN
//   When defined, a scan watchdog raises 'stall' and drops 'valid' if no
//   capture happens for TIMEOUT_CYCLES cycles. When undefined, 'stall' is
//   tied low and the watchdog logic is not built.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   digit[3:0] in   scanned digit select (polarity set by DIG_ACTIVE_LOW)
//   seg[7:0]   in   scanned segments, seg[7]=dp, seg[6:0]=g..a (polarity SEG_ACTIVE_LOW)
//   value[15:0] out decoded word, nibble k belongs to digit k
//   dp[3:0]    out  decoded decimal point per digit
//   valid[3:0] out  legal glyph captured for that digit since reset/clear
//   frame_done out  one-cycle pulse after all four digits were captured
//   err        out  sticky: illegal glyph or multi-hot select seen
//   stall      out  scan watchdog flag
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit,
  input  logic [7:0]  seg,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  valid,
  output logic        frame_done,
  output logic        err,
  output logic        stall
);

  typedef enum logic {SEEK, HOLD} state_t;

  localparam logic [7:0] STABLE   = 8'(STABLE_CYCLES);
  // Reset the input register to the "nothing selected, nothing lit" bus so
  // the first real sample after reset is seen as a change.
  localparam logic [3:0] DIG_IDLE = DIG_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [7:0] SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  state_t      state, state_next;
  logic [3:0]  digit_q;
  logic [7:0]  seg_q;
  logic [3:0]  sel, prev_sel;
  logic [7:0]  pat, prev_pat;
  logic        changed;
  logic [7:0]  cnt, cnt_next;
  logic        stable_now;
  logic        fresh;
  logic        sel_onehot, sel_multi;
  logic        capture, sel_fault;
  logic [1:0]  slot;
  logic        glyph_hit, glyph_blank;
  logic [3:0]  glyph_nib;
  logic [3:0]  mask, mask_next;

  // Glyph table lookup; returns {hit, nibble}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  // Single input register; polarity is normalised after it so all internal
  // logic sees active-high select and segments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q <= DIG_IDLE;
      seg_q   <= SEG_IDLE;
    end else begin
      digit_q <= digit;
      seg_q   <= seg;
    end
  end

  assign sel = DIG_ACTIVE_LOW ? ~digit_q : digit_q;
  assign pat = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

  // Previous sample and the run-length counter of identical samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_sel <= 4'h0;
      prev_pat <= 8'h00;
      cnt      <= 8'd0;
    end else begin
      prev_sel <= sel;
      prev_pat <= pat;
      cnt      <= cnt_next;
    end
  end

  assign changed = ({sel, pat} != {prev_sel, prev_pat});

  // The capture decision looks at the count this edge will produce, so the
  // result appears exactly STABLE_CYCLES edges after the bus is registered.
  always_comb begin
    if (changed)
      cnt_next = 8'd1;
    else if (cnt >= STABLE)
      cnt_next = STABLE;
    else
      cnt_next = cnt + 8'd1;
  end

  assign stable_now = (cnt_next == STABLE);
  assign sel_onehot = $onehot(sel);
  assign sel_multi  = (sel != 4'h0) && !sel_onehot;
  // A sample may be acted on if we are seeking, or if it is brand new (only
  // possible when STABLE_CYCLES is 1 and the slot changes while in HOLD).
  assign fresh      = (state == SEEK) || changed;

  always_comb begin
    slot = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) slot = 2'(i);
    end
  end

  assign {glyph_hit, glyph_nib} = decode_glyph(pat[6:0]);
  assign glyph_blank            = (pat[6:0] == 7'h00);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEEK;
    else      state <= state_next;
  end

  // FSM next state: HOLD makes a long-held glyph capture only once.
  always_comb begin
    state_next = state;
    case (state)
      SEEK: if (capture) state_next = HOLD;
      HOLD: begin
        if (capture)      state_next = HOLD;
        else if (changed) state_next = SEEK;
      end
      default: state_next = SEEK;
    endcase
  end

  // FSM outputs: capture strobe and select-fault strobe.
  always_comb begin
    capture   = 1'b0;
    sel_fault = 1'b0;
    if (fresh && stable_now) begin
      capture   = sel_onehot;
      sel_fault = sel_multi;
    end
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int               WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;

  // Fires on the edge where the cycles-since-capture count reaches the limit.
  assign wd_fire = !capture && (wd_cnt != WD_LIMIT) && ((wd_cnt + WD_W'(1)) == WD_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      stall  <= 1'b0;
    end else if (capture) begin
      wd_cnt <= '0;
      stall  <= 1'b0;
    end else begin
      if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_fire)            stall  <= 1'b1;
    end
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
  assign stall          = 1'b0;
`endif

  // Capture mask: a full mask is cleared on the next edge (frame boundary);
  // blanks count toward the frame, illegal glyphs do not.
  always_comb begin
    mask_next = (mask == 4'hF) ? 4'h0 : mask;
    if (capture && (glyph_blank || glyph_hit)) mask_next[slot] = 1'b1;
`ifdef SCAN_TIMEOUT_EN
    if (wd_fire) mask_next = 4'h0;
`endif
  end

  // Output datapath: decoded word, decimal points, valid flags and errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value      <= 16'h0000;
      dp         <= 4'h0;
      valid      <= 4'h0;
      mask       <= 4'h0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      mask       <= mask_next;
      frame_done <= (mask == 4'hF);
      if (sel_fault) err <= 1'b1;
      if (capture) begin
        if (glyph_blank) begin
          valid[slot] <= 1'b0;
        end else if (glyph_hit) begin
          value[{slot, 2'b00} +: 4] <= glyph_nib;
          dp[slot]                  <= pat[7];
          valid[slot]               <= 1'b1;
        end else begin
          err         <= 1'b1;
          valid[slot] <= 1'b0;
        end
      end
`ifdef SCAN_TIMEOUT_EN
      if (wd_fire) valid <= 4'h0;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
// -------------------
// Self-checking bench for seg_scan_decoder (STABLE_CYCLES=4, active-low bus).
// Hand-written sequences cover reset, latency, glitches and mid-frame reset;
// a vector table covers a full frame and error cases; a random phase is
// compared against a segment-level reference model of the decoder.
module tb_seg_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 50;

  typedef struct {
    logic [3:0]  dig;
    logic [7:0]  sg;
    int          hold;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  valid;
    logic        err;
    int          frames;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  digit = 4'hF;
  logic [7:0]  seg = 8'hFF;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  valid;
  logic        frame_done;
  logic        err;
  logic        stall;

  int checks_total  = 0;
  int checks_passed = 0;
  int frame_count   = 0;
  int frame_base    = 0;

  logic [6:0] glyph [16];
  vec_t       vecs [9];

  // Reference model state (one entry per decoded segment hold).
  logic [15:0] m_value;
  logic [3:0]  m_dp, m_valid, m_mask;
  logic        m_err;
  int          m_frames;
  int          m_gap;

  seg_scan_decoder #(
    .STABLE_CYCLES (STABLE),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit     (digit),
    .seg       (seg),
    .value     (value),
    .dp        (dp),
    .valid     (valid),
    .frame_done(frame_done),
    .err       (err),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  // Count frame pulses away from the active edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) frame_count++;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    digit = 4'hF;
    seg   = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    frame_base = frame_count;
  endtask

  // Hold one bus value for exactly 'd' rising edges, return #1 after the last.
  task automatic apply_stimulus(input logic [3:0] dig, input logic [7:0] sg, input int d);
    @(negedge clk);
    digit = dig;
    seg   = sg;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag);
    check({tag, " value"}, value, m_value);
    check({tag, " dp"}, 16'(dp), 16'(m_dp));
    check({tag, " valid"}, 16'(valid), 16'(m_valid));
    check({tag, " err"}, 16'(err), 16'(m_err));
    check({tag, " stall"}, 16'(stall), 16'h0);
  endtask

  task automatic model_reset();
    m_value  = 16'h0;
    m_dp     = 4'h0;
    m_valid  = 4'h0;
    m_mask   = 4'h0;
    m_err    = 1'b0;
    m_frames = 0;
    m_gap    = 0;
  endtask

  // A hold of d identical samples is acted on once if d >= STABLE.
  task automatic model_segment(input logic [3:0] dig, input logic [7:0] sg, input int d);
    logic [3:0] s;
    logic [7:0] p;
    int         k;
    int         code;
    bit         cap;
    s   = ~dig;
    p   = ~sg;
    k   = 0;
    cap = 0;
    if (d >= STABLE && s != 4'h0) begin
      if ($countones(s) == 1) begin
        cap  = 1;
        code = -1;
        for (int i = 0; i < 4; i++) if (s[i]) k = i;
        for (int i = 0; i < 16; i++) if (glyph[i] == p[6:0]) code = i;
        if (p[6:0] == 7'h00) begin
          m_valid[k] = 1'b0;
          m_mask[k]  = 1'b1;
        end else if (code >= 0) begin
          m_value[k*4 +: 4] = 4'(code);
          m_dp[k]    = p[7];
          m_valid[k] = 1'b1;
          m_mask[k]  = 1'b1;
        end else begin
          m_err      = 1'b1;
          m_valid[k] = 1'b0;
        end
        if (m_mask == 4'hF) begin
          m_frames++;
          m_mask = 4'h0;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    m_gap = cap ? d - STABLE : m_gap + d;
  endtask

  initial begin
    logic [3:0]  dig;
    logic [7:0]  sg;
    logic [11:0] prev;
    logic        dpb;
    int          d;
    int          r;

    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    vecs[0] = '{4'hE, 8'hF9, 7, 16'h0001, 4'h0, 4'h1, 1'b0, 0};
    vecs[1] = '{4'hD, 8'hA4, 7, 16'h0021, 4'h0, 4'h3, 1'b0, 0};
    vecs[2] = '{4'hB, 8'h30, 7, 16'h0321, 4'h4, 4'h7, 1'b0, 0};
    vecs[3] = '{4'h7, 8'h88, 7, 16'hA321, 4'h4, 4'hF, 1'b0, 1};
    vecs[4] = '{4'hE, 8'hFF, 7, 16'hA321, 4'h4, 4'hE, 1'b0, 1};
    vecs[5] = '{4'hE, 8'h00, 7, 16'hA328, 4'h5, 4'hF, 1'b0, 1};
    vecs[6] = '{4'hD, 8'hAA, 7, 16'hA328, 4'h5, 4'hD, 1'b1, 1};
    vecs[7] = '{4'hC, 8'hF9, 7, 16'hA328, 4'h5, 4'hD, 1'b1, 1};
    vecs[8] = '{4'hF, 8'hF9, 7, 16'hA328, 4'h5, 4'hD, 1'b1, 1};

    // Reset held with a toggling bus, then released onto an idle bus.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      digit = 4'($urandom_range(0, 15));
      seg   = 8'($urandom_range(0, 255));
    end
    #1;
    check("reset value", value, 16'h0);
    check("reset flags", 16'({dp, valid, frame_done, err, stall}), 16'h0);
    @(negedge clk);
    digit = 4'hF;
    seg   = 8'hFF;
    rst   = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("idle value", value, 16'h0);
    check("idle flags", 16'({dp, valid, frame_done, err, stall}), 16'h0);

    // Single glyph: capture exactly STABLE edges after the bus registers.
    do_reset();
    @(negedge clk);
    digit = 4'hE;
    seg   = 8'hC0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("single valid e%0d", i), 16'(valid), (i >= STABLE) ? 16'h1 : 16'h0);
    end
    check("single value", value, 16'h0000);
    check("single frames", 16'(frame_count - frame_base), 16'h0);

    // Glitch rejection: holds of STABLE-1 never capture.
    do_reset();
    for (int round = 0; round < 3; round++) begin
      apply_stimulus(4'hE, 8'hF9, 3);
      apply_stimulus(4'hD, 8'hA4, 3);
      apply_stimulus(4'hB, 8'hB0, 3);
      apply_stimulus(4'h7, 8'h88, 3);
    end
    apply_stimulus(4'hF, 8'hFF, 6);
    check("glitch valid", 16'(valid), 16'h0);
    check("glitch frames", 16'(frame_count - frame_base), 16'h0);

    // Vector table: full frame, blank, "8.", illegal glyph, multi-hot select.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].dig, vecs[i].sg, vecs[i].hold);
      check($sformatf("vec%0d value", i), value, vecs[i].value);
      check($sformatf("vec%0d dp", i), 16'(dp), 16'(vecs[i].dp));
      check($sformatf("vec%0d valid", i), 16'(valid), 16'(vecs[i].valid));
      check($sformatf("vec%0d err", i), 16'(err), 16'(vecs[i].err));
      check($sformatf("vec%0d frames", i), 16'(frame_count - frame_base), 16'(vecs[i].frames));
    end

    // Reset mid-frame clears immediately; decoding restarts afterwards.
    do_reset();
    apply_stimulus(4'hE, 8'hF9, 7);
    apply_stimulus(4'hD, 8'hA4, 7);
    check("midrst pre valid", 16'(valid), 16'h3);
    #3;
    rst = 1'b0;
    #1;
    check("midrst value", value, 16'h0);
    check("midrst flags", 16'({dp, valid, frame_done, err}), 16'h0);
    @(negedge clk);
    digit = 4'hB;
    seg   = 8'h30;
    @(negedge clk);
    rst = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("midrst after value", value, 16'h0300);
    check("midrst after dp", 16'(dp), 16'h4);
    check("midrst after valid", 16'(valid), 16'h4);

    // Random segments against the reference model.
    do_reset();
    model_reset();
    prev = {4'hF, 8'hFF};
    for (int n = 0; n < 150; n++) begin
      do begin
        if (m_gap > 30) begin
          dig = ~(4'b0001 << $urandom_range(0, 3));
          dpb = 1'($urandom_range(0, 1));
          sg  = ~{dpb, glyph[$urandom_range(0, 15)]};
          d   = 6;
        end else begin
          r = int'($urandom_range(0, 99));
          if (r < 70) dig = ~(4'b0001 << $urandom_range(0, 3));
          else if (r < 85) dig = 4'hF;
          else begin
            dig = 4'($urandom_range(0, 15));
            while ($countones(dig) > 2) dig = 4'($urandom_range(0, 15));
          end
          r   = int'($urandom_range(0, 99));
          dpb = 1'($urandom_range(0, 1));
          if (r < 70) sg = ~{dpb, glyph[$urandom_range(0, 15)]};
          else if (r < 85) sg = {~dpb, 7'h7F};
          else sg = 8'($urandom_range(0, 255));
          d = int'($urandom_range(1, 9));
        end
      end while ({dig, sg} == prev);
      prev = {dig, sg};
      apply_stimulus(dig, sg, d);
      model_segment(dig, sg, d);
      if (d >= STABLE + 1) check_output($sformatf("rnd%0d", n));
    end
    apply_stimulus(4'hF, 8'hFF, 8);
    check_output("rnd final");
    check("rnd frames", 16'(frame_count - frame_base), 16'(m_frames));

`ifdef SCAN_TIMEOUT_EN
    // Watchdog: full frame, frozen bus, stall at TIMEOUT cycles after capture.
    do_reset();
    apply_stimulus(4'hE, 8'hF9, 7);
    apply_stimulus(4'hD, 8'hA4, 7);
    apply_stimulus(4'hB, 8'h30, 7);
    apply_stimulus(4'h7, 8'h88, 7);
    repeat (TIMEOUT - 3) @(posedge clk);
    #1;
    check("wd before stall", 16'(stall), 16'h0);
    check("wd before valid", 16'(valid), 16'hF);
    @(posedge clk);
    #1;
    check("wd stall", 16'(stall), 16'h1);
    check("wd valid", 16'(valid), 16'h0);
    check("wd value", value, 16'hA321);
    check("wd dp", 16'(dp), 16'h4);
    apply_stimulus(4'hD, 8'hF9, 7);
    check("wd recover stall", 16'(stall), 16'h0);
    check("wd recover valid", 16'(valid), 16'h2);
    check("wd recover value", value, 16'hA311);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
